cache_miss_ctrl: RTL and testbench
==================================

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- NUM_SET, 2, sets per cache.
- WAYS_PER_SET, 2, ways per set.
- NUM_SET_W, clog2(NUM_SET), set index width.
- WAYS_PER_SET_W, clog2(WAYS_PER_SET), way index width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- lookup_valid, in, 1, tag lookup result valid.
- lookup_set, in, NUM_SET_W, set looked up.
- lookup_hit, in, 1, lookup hit.
- lookup_hit_way, in, WAYS_PER_SET_W, hit way.
- victim_req, out, 1, victim query to LRU.
- victim_set, out, NUM_SET_W, set being queried.
- victim_way, in, WAYS_PER_SET_W, LRU victim; combinational, same cycle as victim_req.
- victim_dirty, in, 1, dirty bit of victim_way; same cycle as victim_req.
- wb_req, out, 1, write-back request.
- wb_set, out, NUM_SET_W, write-back set.
- wb_way, out, WAYS_PER_SET_W, write-back way.
- wb_ack, in, 1, write-back done.
- fill_req, out, 1, refill request.
- fill_set, out, NUM_SET_W, refill set.
- fill_way, out, WAYS_PER_SET_W, refill way.
- fill_ack, in, 1, refill done.
- update_req, out, 1, LRU touch.
- update_set, out, NUM_SET_W, set touched.
- update_way, out, WAYS_PER_SET_W, way touched.
- busy, out, 1, miss in progress.
- miss_done, out, 1, one-cycle pulse at miss completion.
- timeout_err, out, 1, one-cycle pulse when a wait is aborted.

Function
REQ-004 All outputs SHALL be registered, except victim_set, which SHALL equal the captured miss set while in VICTIM.
REQ-005 The FSM SHALL have the states IDLE, VICTIM, WRITEBACK, FILL and UPDATE.
REQ-006 In IDLE, lookup_valid&lookup_hit SHALL pulse update_req for exactly the next cycle with the registered set/way; the state SHALL remain IDLE and busy SHALL stay 0.
REQ-007 In IDLE, lookup_valid&!lookup_hit SHALL capture lookup_set, go to VICTIM next cycle and set busy=1.
REQ-008 VICTIM SHALL last exactly one cycle with victim_req=1; in that cycle the block SHALL capture victim_way and victim_dirty.
REQ-009 From VICTIM, the next state SHALL be WRITEBACK if the captured dirty bit is 1, else FILL.
REQ-010 In WRITEBACK, wb_req SHALL stay 1 with a stable set/way until the cycle wb_ack=1 is sampled; the next state SHALL then be FILL with wb_req=0.
REQ-011 In FILL, fill_req SHALL be held until fill_ack=1 is sampled; the next state SHALL then be UPDATE.
REQ-012 UPDATE SHALL last one cycle with update_req=1 and update_way=victim way, and miss_done SHALL pulse in that same cycle; the next state SHALL be IDLE and busy SHALL drop to 0 on the following cycle.
REQ-013 Minimum miss latency (clean victim, ack on first request cycle) SHALL be 4 cycles from lookup to miss_done.
REQ-014 wb_ack or fill_ack SHALL be ignored when the matching request is 0; acks in other states SHALL have no effect.
REQ-015 lookup_valid SHALL be ignored while busy=1; the requester SHALL re-present the access after miss_done.
REQ-016 If a hit is followed by a miss on the next cycle, the hit's update_req and the miss's victim_req SHALL be allowed to coincide in one cycle.
REQ-017 update_req SHALL never assert for a miss whose FILL has not completed.

Reset
REQ-018 Reset SHALL set the state to IDLE and drive every output request, busy, miss_done and timeout_err to 0, with all set/way outputs 0.
REQ-019 Reset asserted mid-miss SHALL abort the miss with no update_req and no miss_done.

Configuration
REQ-020 With CACHE_MISS_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to WRITEBACK or FILL and increment each waiting cycle.
REQ-021 With CACHE_MISS_TIMEOUT_EN defined, reaching 255 without an ack SHALL drop the request, pulse timeout_err and return to IDLE with no update_req.
REQ-022 Without CACHE_MISS_TIMEOUT_EN, the counter SHALL be absent, timeout_err SHALL be tied to 0 and waits SHALL be unbounded.

Structure
REQ-023 The FSM state encoding and the clog2 function SHALL live in the shared package cache_pkg.
REQ-024 The wait counter SHALL be a sub-module named cache_wait_timer, instantiated only under CACHE_MISS_TIMEOUT_EN.

Verification (NUM_SET=4, WAYS_PER_SET=4)
REQ-025 Hit on set 2, way 3 -> update_req=1 with set 2, way 3 for exactly the next cycle; busy stays 0.
REQ-026 Miss on set 1, victim_way=2, dirty=0, fill_ack on the first cycle -> no wb_req, fill_req to set 1 way 2, update set 1 way 2 and miss_done 4 cycles after the lookup.
REQ-027 Miss on set 3, victim_way=0, dirty=1, wb_ack after 5 cycles, fill_ack after 3 cycles -> wb_req held 5 cycles, then fill_req held 3 cycles, then update set 3 way 0.
REQ-028 lookup_valid pulsed during FILL -> ignored, with no extra update_req; reset during WRITEBACK -> all outputs 0 on the next cycle and no miss_done.
REQ-029 With CACHE_MISS_TIMEOUT_EN defined and fill_ack never asserted -> fill_req drops after 255 cycles, timeout_err pulses once, busy goes to 0 and no update_req is issued.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the cache miss controller.
//   miss_state_e : miss-handling FSM state encoding
//   clog2        : index-width helper used for parameter defaults
//   WAIT_CNT_W   : width of the optional wait counter
//   WAIT_LAST    : counter value seen in the 255th waiting cycle
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VICTIM    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        UPDATE    = 3'd4
    } miss_state_e;

    localparam int unsigned WAIT_CNT_W = 8;

    // The counter starts at 0 in the first waiting cycle, so it holds 254
    // in the 255th; the wait is aborted at the end of that cycle.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(254);

    // Ceiling log2, never less than 1 so index ports keep a legal width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/cache_wait_timer.sv
// cache_wait_timer: wait-cycle counter for the miss controller, only
// instantiated when CACHE_MISS_TIMEOUT_EN is defined.
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the count (entry into a wait state)
//   enable       : advance the count by one this cycle
//   count        : current wait count
module cache_wait_timer
    import cache_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    output logic [WAIT_CNT_W-1:0] count
);

    // Clear wins over enable so a fresh wait always starts from 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: sequences a cache miss through victim selection, optional
// write-back, refill and LRU update; touches the LRU directly on hits.
// Optional feature macro: CACHE_MISS_TIMEOUT_EN (bounded waits, timeout_err).
//   clock, reset          : clock, synchronous active-high reset
//   lookup_*              : tag lookup result from the pipeline
//   victim_req/set        : LRU victim query (victim_set is combinational)
//   victim_way/dirty      : LRU answer, valid in the victim_req cycle
//   wb_req/set/way/ack    : write-back handshake
//   fill_req/set/way/ack  : refill handshake
//   update_req/set/way    : LRU touch
//   busy, miss_done       : miss in progress, completion pulse
//   timeout_err           : pulse when a wait is aborted (0 without the macro)
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned NUM_SET        = 2,
    parameter int unsigned WAYS_PER_SET   = 2,
    parameter int unsigned NUM_SET_W      = clog2(NUM_SET),
    parameter int unsigned WAYS_PER_SET_W = clog2(WAYS_PER_SET)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      lookup_valid,
    input  logic [NUM_SET_W-1:0]      lookup_set,
    input  logic                      lookup_hit,
    input  logic [WAYS_PER_SET_W-1:0] lookup_hit_way,
    output logic                      victim_req,
    output logic [NUM_SET_W-1:0]      victim_set,
    input  logic [WAYS_PER_SET_W-1:0] victim_way,
    input  logic                      victim_dirty,
    output logic                      wb_req,
    output logic [NUM_SET_W-1:0]      wb_set,
    output logic [WAYS_PER_SET_W-1:0] wb_way,
    input  logic                      wb_ack,
    output logic                      fill_req,
    output logic [NUM_SET_W-1:0]      fill_set,
    output logic [WAYS_PER_SET_W-1:0] fill_way,
    input  logic                      fill_ack,
    output logic                      update_req,
    output logic [NUM_SET_W-1:0]      update_set,
    output logic [WAYS_PER_SET_W-1:0] update_way,
    output logic                      busy,
    output logic                      miss_done,
    output logic                      timeout_err
);

    miss_state_e          state;
    logic [NUM_SET_W-1:0] miss_set;
    logic                 wait_expired;

    // The LRU answers combinationally, so the set is presented only while querying.
    assign victim_set = (state == VICTIM) ? miss_set : '0;

`ifdef CACHE_MISS_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  wait_clear;
    logic                  wait_enable;

    // Restart the count on every entry into WRITEBACK or FILL.
    assign wait_clear  = (state == VICTIM) || ((state == WRITEBACK) && wb_ack);
    assign wait_enable = (state == WRITEBACK) || (state == FILL);

    cache_wait_timer u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_enable),
        .count  (wait_count)
    );

    assign wait_expired = wait_enable && (wait_count == WAIT_LAST);
`else
    assign wait_expired = 1'b0;
`endif

    // Miss FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            miss_set    <= '0;
            victim_req  <= 1'b0;
            wb_req      <= 1'b0;
            wb_set      <= '0;
            wb_way      <= '0;
            fill_req    <= 1'b0;
            fill_set    <= '0;
            fill_way    <= '0;
            update_req  <= 1'b0;
            update_set  <= '0;
            update_way  <= '0;
            busy        <= 1'b0;
            miss_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            update_req  <= 1'b0;
            miss_done   <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (lookup_valid && lookup_hit) begin
                        update_req <= 1'b1;
                        update_set <= lookup_set;
                        update_way <= lookup_hit_way;
                    end else if (lookup_valid) begin
                        miss_set   <= lookup_set;
                        victim_req <= 1'b1;
                        busy       <= 1'b1;
                        state      <= VICTIM;
                    end
                end
                VICTIM: begin
                    // Victim way/dirty are only valid in this cycle.
                    victim_req <= 1'b0;
                    if (victim_dirty) begin
                        wb_req <= 1'b1;
                        wb_set <= miss_set;
                        wb_way <= victim_way;
                        state  <= WRITEBACK;
                    end else begin
                        fill_req <= 1'b1;
                        fill_set <= miss_set;
                        fill_way <= victim_way;
                        state    <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (wb_ack) begin
                        wb_req   <= 1'b0;
                        fill_req <= 1'b1;
                        fill_set <= wb_set;
                        fill_way <= wb_way;
                        state    <= FILL;
                    end else if (wait_expired) begin
                        wb_req      <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                FILL: begin
                    if (fill_ack) begin
                        fill_req   <= 1'b0;
                        update_req <= 1'b1;
                        update_set <= fill_set;
                        update_way <= fill_way;
                        miss_done  <= 1'b1;
                        state      <= UPDATE;
                    end else if (wait_expired) begin
                        fill_req    <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                UPDATE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed self-checking bench for cache_miss_ctrl
// configured with 4 sets x 4 ways.
module tb_cache_miss_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       lookup_valid = 1'b0;
    logic [1:0] lookup_set = 2'd0;
    logic       lookup_hit = 1'b0;
    logic [1:0] lookup_hit_way = 2'd0;
    logic       victim_req;
    logic [1:0] victim_set;
    logic [1:0] victim_way = 2'd0;
    logic       victim_dirty = 1'b0;
    logic       wb_req;
    logic [1:0] wb_set;
    logic [1:0] wb_way;
    logic       wb_ack = 1'b0;
    logic       fill_req;
    logic [1:0] fill_set;
    logic [1:0] fill_way;
    logic       fill_ack = 1'b0;
    logic       update_req;
    logic [1:0] update_set;
    logic [1:0] update_way;
    logic       busy;
    logic       miss_done;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int done_cnt = 0;
    int to_cnt = 0;

    cache_miss_ctrl #(
        .NUM_SET      (4),
        .WAYS_PER_SET (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_set     (lookup_set),
        .lookup_hit     (lookup_hit),
        .lookup_hit_way (lookup_hit_way),
        .victim_req     (victim_req),
        .victim_set     (victim_set),
        .victim_way     (victim_way),
        .victim_dirty   (victim_dirty),
        .wb_req         (wb_req),
        .wb_set         (wb_set),
        .wb_way         (wb_way),
        .wb_ack         (wb_ack),
        .fill_req       (fill_req),
        .fill_set       (fill_set),
        .fill_way       (fill_way),
        .fill_ack       (fill_ack),
        .update_req     (update_req),
        .update_set     (update_set),
        .update_way     (update_way),
        .busy           (busy),
        .miss_done      (miss_done),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (update_req)  upd_cnt  <= upd_cnt + 1;
            if (miss_done)   done_cnt <= done_cnt + 1;
            if (timeout_err) to_cnt   <= to_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic hit, input logic [1:0] set, input logic [1:0] way);
        lookup_valid   = 1'b1;
        lookup_hit     = hit;
        lookup_set     = set;
        lookup_hit_way = way;
        step();
        lookup_valid   = 1'b0;
        lookup_hit     = 1'b0;
    endtask

    int n_upd;
    int n_done;
    int held;

    initial begin
        // Reset
        step();
        step();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_update_req", update_req, 0);
        check("rst_wb_req", wb_req, 0);
        check("rst_fill_req", fill_req, 0);
        check("rst_victim_req", victim_req, 0);
        check("rst_miss_done", miss_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_update_set", update_set, 0);

        // Hit on set 2 way 3: one-cycle LRU touch, stays idle
        lookup(1'b1, 2'd2, 2'd3);
        check("hit_update_req", update_req, 1);
        check("hit_update_set", update_set, 2);
        check("hit_update_way", update_way, 3);
        check("hit_busy", busy, 0);
        step();
        check("hit_update_req_drop", update_req, 0);
        check("hit_busy_after", busy, 0);

        // Clean miss on set 1, victim way 2, fill acked in first cycle
        victim_way   = 2'd2;
        victim_dirty = 1'b0;
        lookup(1'b0, 2'd1, 2'd0);                     // lookup cycle = 1st
        check("clean_victim_req", victim_req, 1);      // 2nd
        check("clean_victim_set", victim_set, 1);
        check("clean_busy", busy, 1);
        step();
        check("clean_no_wb", wb_req, 0);               // 3rd
        check("clean_fill_req", fill_req, 1);
        check("clean_fill_set", fill_set, 1);
        check("clean_fill_way", fill_way, 2);
        check("clean_victim_req_drop", victim_req, 0);
        check("clean_victim_set_idle", victim_set, 0);
        fill_ack = 1'b1;
        step();
        fill_ack = 1'b0;
        check("clean_miss_done", miss_done, 1);        // 4th cycle from lookup
        check("clean_update_req", update_req, 1);
        check("clean_update_set", update_set, 1);
        check("clean_update_way", update_way, 2);
        check("clean_fill_drop", fill_req, 0);
        check("clean_busy_update", busy, 1);
        step();
        check("clean_busy_drop", busy, 0);
        check("clean_done_drop", miss_done, 0);

        // Dirty miss on set 3, victim way 0: wb 5 cycles, fill 3 cycles
        victim_way   = 2'd0;
        victim_dirty = 1'b1;
        lookup(1'b0, 2'd3, 2'd0);
        check("dirty_victim_req", victim_req, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("dirty_wb_req", wb_req, 1);
            check("dirty_wb_set", wb_set, 3);
            check("dirty_wb_way", wb_way, 0);
            check("dirty_no_fill", fill_req, 0);
            if (i == 4) wb_ack = 1'b1;
            step();
        end
        wb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("dirty_wb_drop", wb_req, 0);
            check("dirty_fill_req", fill_req, 1);
            check("dirty_fill_set", fill_set, 3);
            check("dirty_fill_way", fill_way, 0);
            check("dirty_no_update", update_req, 0);
            if (i == 2) fill_ack = 1'b1;
            step();
        end
        fill_ack = 1'b0;
        check("dirty_update_req", update_req, 1);
        check("dirty_update_set", update_set, 3);
        check("dirty_update_way", update_way, 0);
        check("dirty_miss_done", miss_done, 1);
        step();

        // Lookup during FILL is ignored
        victim_way   = 2'd1;
        victim_dirty = 1'b0;
        lookup(1'b0, 2'd0, 2'd0);
        step();
        n_upd = upd_cnt;
        lookup(1'b1, 2'd2, 2'd1);
        check("busy_lookup_no_update", update_req, 0);
        check("busy_lookup_fill_held", fill_req, 1);
        fill_ack = 1'b1;
        step();
        fill_ack = 1'b0;
        check("busy_lookup_update_set", update_set, 0);
        check("busy_lookup_update_way", update_way, 1);
        step();
        check("busy_lookup_one_update", upd_cnt, n_upd + 1);

        // Reset during WRITEBACK aborts the miss
        victim_dirty = 1'b1;
        victim_way   = 2'd3;
        lookup(1'b0, 2'd2, 2'd0);
        step();
        check("abort_wb_req", wb_req, 1);
        n_done = done_cnt;
        n_upd  = upd_cnt;
        reset = 1'b1;
        step();
        check("abort_wb_req_zero", wb_req, 0);
        check("abort_wb_set_zero", wb_set, 0);
        check("abort_wb_way_zero", wb_way, 0);
        check("abort_busy_zero", busy, 0);
        check("abort_fill_zero", fill_req, 0);
        check("abort_update_zero", update_req, 0);
        reset = 1'b0;
        victim_dirty = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_no_done", done_cnt, n_done);
        check("abort_no_update", upd_cnt, n_upd);
        check("abort_idle", busy, 0);

`ifdef CACHE_MISS_TIMEOUT_EN
        // Fill never acked: request dropped after 255 cycles
        n_upd = upd_cnt;
        lookup(1'b0, 2'd1, 2'd0);
        step();
        held = 0;
        for (int i = 0; i < 300 && fill_req === 1'b1; i++) begin
            held++;
            step();
        end
        check("timeout_fill_cycles", held, 255);
        check("timeout_err_pulse", timeout_err, 1);
        check("timeout_busy", busy, 0);
        step();
        check("timeout_err_drop", timeout_err, 0);
        step();
        check("timeout_err_once", to_cnt, 1);
        check("timeout_no_update", upd_cnt, n_upd);
`else
        // Without the timeout a fill wait is unbounded
        lookup(1'b0, 2'd1, 2'd0);
        step();
        held = 0;
        for (int i = 0; i < 300; i++) begin
            if (fill_req === 1'b1) held++;
            step();
        end
        check("nowait_fill_held", held, 300);
        check("nowait_no_timeout", to_cnt, 0);
        fill_ack = 1'b1;
        step();
        fill_ack = 1'b0;
        check("nowait_update_req", update_req, 1);
        check("nowait_miss_done", miss_done, 1);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
